// File: rtl/vt_pkg.sv
// rtl/vt_pkg.sv - Volt Tackle sequencer state encodings, frame constants and Moore output decode
package vt_pkg;

    typedef logic [2:0] vt_state_t;

    localparam vt_state_t ST_IDLE   = 3'd0;
    localparam vt_state_t ST_DRAW_P = 3'd1;
    localparam vt_state_t ST_STEP   = 3'd2;
    localparam vt_state_t ST_WAIT_F = 3'd3;
    localparam vt_state_t ST_DRAW_M = 3'd4;
    localparam vt_state_t ST_HOLD   = 3'd5;
    localparam vt_state_t ST_FIN    = 3'd6;

    localparam int VT_SHIFT_FRAME = 50;
    localparam int VT_END_FRAME   = 60;

    typedef struct packed {
        logic enable_animate;
        logic enable_p_vt;
        logic draw_pika;
        logic draw_meowth;
        logic choose;
        logic plot;
        logic busy;
        logic done_move;
    } vt_out_t;

    // busy is low in FIN so it never overlaps the done_move pulse
    function automatic vt_out_t vt_decode(input vt_state_t s);
        vt_out_t o;
        o = '0;
        case (s)
            ST_DRAW_P: begin
                o.enable_animate = 1'b1;
                o.draw_pika      = 1'b1;
                o.plot           = 1'b1;
            end
            ST_STEP: begin
                o.enable_animate = 1'b1;
                o.enable_p_vt    = 1'b1;
            end
            ST_WAIT_F: o.enable_animate = 1'b1;
            ST_DRAW_M: begin
                o.enable_animate = 1'b1;
                o.draw_meowth    = 1'b1;
                o.plot           = 1'b1;
                o.choose         = 1'b1;
            end
            ST_HOLD: o.enable_animate = 1'b1;
            ST_FIN:  o.done_move      = 1'b1;
            default: o = '0;
        endcase
        o.busy = (s != ST_IDLE) && (s != ST_FIN);
        return o;
    endfunction

endpackage

// File: rtl/volt_tackle_control_if.sv
// rtl/volt_tackle_control_if.sv - control/status bundle between battle FSM, move datapath and sequencer
interface volt_tackle_control_if;
    logic       go;
    logic       abort;
    logic       done_pikachu_vt;
    logic       done_hurt_meowth;
    logic       done_animate_vt;
    logic       done_shift;
    logic       done_vt;
    logic       enable_animate;
    logic       enable_p_vt;
    logic       enable_draw_pika_vt;
    logic       enable_draw_hurt_meowth;
    logic       choose;
    logic       plot;
    logic       busy;
    logic       done_move;
    logic [5:0] frame_cnt;
    logic       err_timeout;

    modport master (
        output go, abort, done_pikachu_vt, done_hurt_meowth, done_animate_vt, done_shift, done_vt,
        input  enable_animate, enable_p_vt, enable_draw_pika_vt, enable_draw_hurt_meowth,
               choose, plot, busy, done_move, frame_cnt, err_timeout
    );

    modport slave (
        input  go, abort, done_pikachu_vt, done_hurt_meowth, done_animate_vt, done_shift, done_vt,
        output enable_animate, enable_p_vt, enable_draw_pika_vt, enable_draw_hurt_meowth,
               choose, plot, busy, done_move, frame_cnt, err_timeout
    );
endinterface

// File: rtl/vt_watchdog.sv
// rtl/vt_watchdog.sv - per-state timeout counter, built only with VT_WATCHDOG_EN
`ifdef VT_WATCHDOG_EN
module vt_watchdog #(
    parameter int CYCLES = 2000000,
    parameter int W      = 22
) (
    input  logic clock,
    input  logic reset_all,
    input  logic active,
    input  logic restart,
    output logic expired
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart || !active) cnt_d = '0;
        else                    cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_all) begin
        if (!reset_all) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end

    assign expired = active && (cnt_q == W'(CYCLES - 1));
endmodule
`endif

// File: rtl/volt_tackle_control.sv
// rtl/volt_tackle_control.sv - Volt Tackle move sequencer (pikachu redraw loop, meowth draw, hold, done)
// Optional per-state watchdog enabled by VT_WATCHDOG_EN.
module volt_tackle_control
    import vt_pkg::*;
#(
    parameter int WDOG_CYCLES = 2000000,
    parameter int WDOG_W      = 22
) (
    input logic                  clock,
    input logic                  reset_all,
    volt_tackle_control_if.slave vt
);
    vt_state_t  state_q, state_d;
    vt_out_t    out_q, out_d;
    logic [5:0] frame_cnt_q, frame_cnt_d;
    logic       shift_seen_q, shift_seen_d;
    logic       vt_seen_q, vt_seen_d;
    logic       wdog_expired;
    logic       start;

    if (WDOG_CYCLES >= 2**WDOG_W) begin : g_wdog_w_check
        $error("WDOG_W cannot hold WDOG_CYCLES");
    end

    assign start = (state_q == ST_IDLE) && vt.go && !vt.abort;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (vt.go) state_d = ST_DRAW_P;
            ST_DRAW_P: if (vt.done_pikachu_vt) state_d = ST_STEP;
            ST_STEP:   state_d = ST_WAIT_F;
            ST_WAIT_F: if (vt.done_animate_vt)
                           state_d = (vt.done_shift || shift_seen_q) ? ST_DRAW_M : ST_DRAW_P;
            ST_DRAW_M: if (vt.done_hurt_meowth) state_d = ST_HOLD;
            ST_HOLD:   if (vt.done_vt || vt_seen_q) state_d = ST_FIN;
            ST_FIN:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (vt.abort || wdog_expired) state_d = ST_IDLE;
    end

    // Early shift / end events are remembered so later states do not miss them
    always_comb begin
        shift_seen_d = shift_seen_q | vt.done_shift;
        vt_seen_d    = vt_seen_q | vt.done_vt;
        if (state_q == ST_IDLE) begin
            shift_seen_d = 1'b0;
            vt_seen_d    = 1'b0;
        end
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (start)
            frame_cnt_d = '0;
        else if (state_q == ST_STEP && frame_cnt_q != 6'h3f)
            frame_cnt_d = frame_cnt_q + 6'd1;
    end

    assign out_d = vt_decode(state_d);

    always_ff @(posedge clock or negedge reset_all) begin
        if (!reset_all) begin
            state_q      <= ST_IDLE;
            out_q        <= '0;
            frame_cnt_q  <= '0;
            shift_seen_q <= 1'b0;
            vt_seen_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_q        <= out_d;
            frame_cnt_q  <= frame_cnt_d;
            shift_seen_q <= shift_seen_d;
            vt_seen_q    <= vt_seen_d;
        end
    end

`ifdef VT_WATCHDOG_EN
    logic err_q, err_d;

    vt_watchdog #(
        .CYCLES (WDOG_CYCLES),
        .W      (WDOG_W)
    ) u_wdog (
        .clock     (clock),
        .reset_all (reset_all),
        .active    (state_q != ST_IDLE),
        .restart   (state_d != state_q),
        .expired   (wdog_expired)
    );

    always_comb begin
        err_d = err_q;
        if (start)             err_d = 1'b0;
        else if (wdog_expired) err_d = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_all) begin
        if (!reset_all) err_q <= 1'b0;
        else            err_q <= err_d;
    end

    assign vt.err_timeout = err_q;
`else
    assign wdog_expired   = 1'b0;
    assign vt.err_timeout = 1'b0;
`endif

    assign vt.enable_animate          = out_q.enable_animate;
    assign vt.enable_p_vt             = out_q.enable_p_vt;
    assign vt.enable_draw_pika_vt     = out_q.draw_pika;
    assign vt.enable_draw_hurt_meowth = out_q.draw_meowth;
    assign vt.choose                  = out_q.choose;
    assign vt.plot                    = out_q.plot;
    assign vt.busy                    = out_q.busy;
    assign vt.done_move               = out_q.done_move;
    assign vt.frame_cnt               = frame_cnt_q;
endmodule
